player_ready_manager: RTL and testbench
=======================================

// Module: player_ready_manager
// PURPOSE
//  Per-player front end for the menu: turns four raw push-buttons into the four
//  *_ready_to_play levels consumed by menu_manager. Buttons toggle readiness while in menu and countdown==0.
//  Readiness locks once menu_manager starts counting down and stays locked until reset.
//  Sits between the board buttons and menu_manager; reads back is_in_menu and countdown.
// PARAMETERS
//  DEBOUNCE_CLK_COUNT  500000  cycles a synced level must disagree with debounced level before update (>=1)
// PORTS
//  clk                   in   1  system clock
//  reset                 in   1  asynchronous, active-high; clears all state
//  green_btn             in   1  raw button, async to clk, active-high
//  red_btn               in   1  raw button, async to clk, active-high
//  blue_btn              in   1  raw button, async to clk, active-high
//  yellow_btn            in   1  raw button, async to clk, active-high
//  is_in_menu            in   1  from menu_manager
//  countdown             in   3  from menu_manager; 0 = countdown not started
//  green_ready_to_play   out  1  registered ready level
//  red_ready_to_play     out  1  registered ready level
//  blue_ready_to_play    out  1  registered ready level
//  yellow_ready_to_play  out  1  registered ready level
//  ready_count           out  3  registered popcount of the four ready outputs (0..4)
//  activity              out  1  one-cycle pulse when any slot changes state on a press
// BEHAVIOUR
//  - Reset (async assert, sync release): all ready=0, ready_count=0, activity=0, slot FSMs=IDLE,
//    sync flops=0, debounced levels=0, debounce counters=0.
//  - Per slot, identical and independent:
//    * 2-flop synchronizer on raw button.
//    * Debounce: counter increments each cycle synced!=debounced, clears when equal; when it would
//      reach DEBOUNCE_CLK_COUNT, debounced<=synced and counter<=0. Width $clog2(DEBOUNCE_CLK_COUNT+1).
//    * press = debounced rising edge, one-cycle pulse (registered previous debounced level).
//    * FSM states IDLE / READY / LOCKED; ready output = (state != IDLE).
//      IDLE  : press & is_in_menu & countdown==0 -> READY
//      READY : countdown!=0 -> LOCKED (takes priority over press same cycle)
//              else press & is_in_menu -> IDLE
//      LOCKED: hold; ignores press, is_in_menu, countdown; exits only via reset.
//    * IDLE with is_in_menu==0 or countdown!=0: presses ignored (no late joining).
//  - Latency: ready changes on the edge after the press pulse cycle; a clean raw edge held stable
//    reaches the ready output 2 + DEBOUNCE_CLK_COUNT + 2 cycles after first sampled.
//  - ready_count updates one cycle after ready outputs; activity asserted one cycle after any slot
//    FSM transition caused by press (lock transitions do NOT pulse activity).
//  - Simultaneous presses on several slots: all handled same cycle; activity single pulse.
//  - Glitches shorter than DEBOUNCE_CLK_COUNT cycles: no change, counter restarts.
//  - Button held through reset release: debounced starts at 0, so it counts as a new press.
//  - Reset mid-countdown: everything returns to IDLE immediately, regardless of inputs.
// STRUCTURE
//  - Shared package/header menu_pkg: SLOT_IDLE=2'd0, SLOT_READY=2'd1, SLOT_LOCKED=2'd2,
//    player index constants GREEN=0, RED=1, BLUE=2, YELLOW=3.
//  - Sub-module player_ready_slot (sync + debounce + edge + FSM; outputs ready, press_accepted),
//    instantiated 4x; top adds popcount and activity register.
// TESTING (DEBOUNCE_CLK_COUNT=4)
//  - Reset then idle 20 cycles -> all ready=0, ready_count=0, activity never 1.
//  - green_btn high, is_in_menu=1, countdown=0 -> green_ready=1 exactly 8 cycles later,
//    ready_count=1 next cycle, one activity pulse; release and press again -> green_ready=0.
//  - red_btn pulse 3 cycles wide -> red_ready stays 0, activity stays 0.
//  - green+blue ready, countdown driven to 7 -> both LOCKED; further green presses keep
//    green_ready=1, no activity; yellow press ignored, ready_count stays 2.
//  - is_in_menu=0, countdown=0, press yellow -> yellow_ready stays 0.
//  - all four pressed same cycle -> all ready same cycle, ready_count=4, single activity pulse;
//    assert reset mid-countdown -> all outputs 0 within the reset cycle.

Source files
------------

// File: rtl/player_ready_manager_pkg.sv
// menu_pkg: slot FSM encoding, player indices and popcount helper shared by the ready manager.
package menu_pkg;
  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'd0,
    SLOT_READY  = 2'd1,
    SLOT_LOCKED = 2'd2
  } slot_state_t;
  localparam int GREEN  = 0;
  localparam int RED    = 1;
  localparam int BLUE   = 2;
  localparam int YELLOW = 3;
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/player_ready_manager_if.sv
// player_ready_manager_if: buttons and menu status in, per-player ready levels out.
interface player_ready_manager_if;
  logic       green_btn;
  logic       red_btn;
  logic       blue_btn;
  logic       yellow_btn;
  logic       is_in_menu;
  logic [2:0] countdown;
  logic       green_ready_to_play;
  logic       red_ready_to_play;
  logic       blue_ready_to_play;
  logic       yellow_ready_to_play;
  logic [2:0] ready_count;
  logic       activity;
  modport master (
    output green_btn, red_btn, blue_btn, yellow_btn, is_in_menu, countdown,
    input  green_ready_to_play, red_ready_to_play, blue_ready_to_play, yellow_ready_to_play,
    input  ready_count, activity
  );
  modport slave (
    input  green_btn, red_btn, blue_btn, yellow_btn, is_in_menu, countdown,
    output green_ready_to_play, red_ready_to_play, blue_ready_to_play, yellow_ready_to_play,
    output ready_count, activity
  );
endinterface

// File: rtl/player_ready_manager_slot.sv
// player_ready_slot: one button through sync, debounce, edge detect and the ready/lock FSM.
module player_ready_slot
  import menu_pkg::*;
#(
  parameter int DEBOUNCE_CLK_COUNT = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       is_in_menu,
  input  logic [2:0] countdown,
  output logic       ready,
  output logic       press_accepted
);
  localparam int CW = $clog2(DEBOUNCE_CLK_COUNT + 1);
  logic          sync1, sync2, debounced, debounced_q, press;
  logic [CW-1:0] cnt;
  slot_state_t   state;
  // press is registered so a stable raw edge reaches ready 2 + N + 2 cycles later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1          <= 1'b0;
      sync2          <= 1'b0;
      debounced      <= 1'b0;
      debounced_q    <= 1'b0;
      press          <= 1'b0;
      cnt            <= '0;
      state          <= SLOT_IDLE;
      ready          <= 1'b0;
      press_accepted <= 1'b0;
    end else begin
      sync1          <= btn;
      sync2          <= sync1;
      debounced_q    <= debounced;
      press          <= debounced & ~debounced_q;
      press_accepted <= 1'b0;
      if (sync2 == debounced) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CLK_COUNT - 1)) begin
        debounced <= sync2;
        cnt       <= '0;
      end else cnt <= cnt + 1'b1;
      unique case (state)
        SLOT_IDLE:
          if (press && is_in_menu && countdown == 3'd0) begin
            state          <= SLOT_READY;
            ready          <= 1'b1;
            press_accepted <= 1'b1;
          end
        SLOT_READY:
          if (countdown != 3'd0) state <= SLOT_LOCKED;
          else if (press && is_in_menu) begin
            state          <= SLOT_IDLE;
            ready          <= 1'b0;
            press_accepted <= 1'b1;
          end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/player_ready_manager.sv
// player_ready_manager: four independent ready slots plus registered ready count and activity pulse.
module player_ready_manager
  import menu_pkg::*;
#(
  parameter int DEBOUNCE_CLK_COUNT = 500000
) (
  input logic                   clk,
  input logic                   reset,
  player_ready_manager_if.slave bus
);
  logic [3:0] btn, ready, accepted;
  assign btn[GREEN]  = bus.green_btn;
  assign btn[RED]    = bus.red_btn;
  assign btn[BLUE]   = bus.blue_btn;
  assign btn[YELLOW] = bus.yellow_btn;
  for (genvar i = 0; i < 4; i++) begin : g_slot
    player_ready_slot #(.DEBOUNCE_CLK_COUNT(DEBOUNCE_CLK_COUNT)) u_slot (
      .clk            (clk),
      .reset          (reset),
      .btn            (btn[i]),
      .is_in_menu     (bus.is_in_menu),
      .countdown      (bus.countdown),
      .ready          (ready[i]),
      .press_accepted (accepted[i])
    );
  end
  assign bus.green_ready_to_play  = ready[GREEN];
  assign bus.red_ready_to_play    = ready[RED];
  assign bus.blue_ready_to_play   = ready[BLUE];
  assign bus.yellow_ready_to_play = ready[YELLOW];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ready_count <= 3'd0;
      bus.activity    <= 1'b0;
    end else begin
      bus.ready_count <= popcount4(ready);
      bus.activity    <= |accepted;
    end
  end
endmodule

// File: tb/tb_player_ready_manager.sv
// tb_player_ready_manager: directed checks of latency, debounce, locking and reset with N=4.
module tb_player_ready_manager;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   act_cnt = 0;
  int   a0;
  player_ready_manager_if bus();
  player_ready_manager #(.DEBOUNCE_CLK_COUNT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (!reset && bus.activity) act_cnt++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_btns(input logic [3:0] b);
    bus.green_btn  = b[0];
    bus.red_btn    = b[1];
    bus.blue_btn   = b[2];
    bus.yellow_btn = b[3];
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input logic [3:0] b);
    set_btns(b);
    tick(12);
    set_btns(4'b0);
    tick(12);
  endtask
  function automatic logic [3:0] rdy();
    return {bus.yellow_ready_to_play, bus.blue_ready_to_play, bus.red_ready_to_play,
            bus.green_ready_to_play};
  endfunction
  initial begin
    set_btns(4'b0);
    bus.is_in_menu = 1'b0;
    bus.countdown  = 3'd0;
    tick(3);
    reset = 1'b0;
    check("reset_ready", 32'(rdy()), 32'h0);
    check("reset_count", 32'(bus.ready_count), 32'd0);
    check("reset_activity", 32'(bus.activity), 32'd0);
    tick(20);
    check("idle_ready", 32'(rdy()), 32'h0);
    check("idle_activity", 32'(act_cnt), 32'd0);
    bus.is_in_menu = 1'b1;
    a0 = act_cnt;
    set_btns(4'b0001);
    tick(7);
    check("green_lat7", 32'(rdy()), 32'h0);
    tick(1);
    check("green_lat8", 32'(rdy()), 32'h1);
    check("green_count_lag", 32'(bus.ready_count), 32'd0);
    tick(1);
    check("green_count", 32'(bus.ready_count), 32'd1);
    tick(3);
    set_btns(4'b0);
    tick(12);
    check("green_release_hold", 32'(rdy()), 32'h1);
    check("green_activity", 32'(act_cnt - a0), 32'd1);
    press(4'b0001);
    check("green_toggle_off", 32'(rdy()), 32'h0);
    check("green_off_count", 32'(bus.ready_count), 32'd0);
    a0 = act_cnt;
    bus.red_btn = 1'b1;
    tick(3);
    bus.red_btn = 1'b0;
    tick(15);
    check("red_glitch", 32'(rdy()), 32'h0);
    check("red_glitch_act", 32'(act_cnt - a0), 32'd0);
    press(4'b0101);
    check("gb_ready", 32'(rdy()), 32'h5);
    check("gb_count", 32'(bus.ready_count), 32'd2);
    a0 = act_cnt;
    bus.countdown = 3'd7;
    tick(3);
    press(4'b0001);
    check("locked_green", 32'(rdy()), 32'h5);
    press(4'b1000);
    check("late_yellow", 32'(rdy()), 32'h5);
    check("locked_count", 32'(bus.ready_count), 32'd2);
    check("locked_activity", 32'(act_cnt - a0), 32'd0);
    reset = 1'b1;
    bus.countdown  = 3'd0;
    bus.is_in_menu = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);
    press(4'b1000);
    check("not_in_menu", 32'(rdy()), 32'h0);
    bus.is_in_menu = 1'b1;
    a0 = act_cnt;
    set_btns(4'b1111);
    tick(7);
    check("all_lat7", 32'(rdy()), 32'h0);
    tick(1);
    check("all_lat8", 32'(rdy()), 32'hf);
    tick(1);
    check("all_count", 32'(bus.ready_count), 32'd4);
    tick(3);
    set_btns(4'b0);
    tick(12);
    check("all_activity", 32'(act_cnt - a0), 32'd1);
    bus.countdown = 3'd3;
    tick(3);
    set_btns(4'b1111);
    tick(2);
    reset = 1'b1;
    #1;
    check("rst_mid_ready", 32'(rdy()), 32'h0);
    check("rst_mid_count", 32'(bus.ready_count), 32'd0);
    check("rst_mid_act", 32'(bus.activity), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(14);
    check("post_rst_countdown", 32'(rdy()), 32'h0);
    check("post_rst_count", 32'(bus.ready_count), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
